// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time controller for the 50 MHz clock divider
//
// Holds a programmable half-period H and produces a 50 % duty divided clock
// with period 2*(H+1) input cycles. The clock starts and stops without
// glitches. New half-periods arrive over a valid/ready handshake and are
// only applied on a full-period boundary while the clock is running.
//
// Ports:
//   clk_50MHz  in   system clock, all logic on its rising edge
//   reset_n    in   synchronous active-low reset
//   en         in   level request to run the divided clock
//   cfg_valid  in   new half-period offered
//   cfg_half   in   offered half-period (any value, 0 gives 25 MHz)
//   cfg_ready  out  controller accepts a config this cycle
//   clk_out    out  registered divided clock
//   tick       out  one-cycle pulse on the first high cycle of each period
//   running    out  high while counting (RUN or DRAIN)
module clk_div_ctrl #(
  parameter int               CNT_W        = 18,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(249999)
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] half, half_n;
  logic [CNT_W-1:0] pend_val, pend_val_n;
  logic             pend, pend_n;
  logic             clk_q, clk_n;
  logic             tick_q, tick_n;

  logic hs;
  logic term;
  logic stop_now;

  // In STOP the half-period register is written directly, so a config is
  // always welcome there; while counting only one value may wait.
  assign cfg_ready = (state == ST_STOP) || !pend;
  assign hs        = cfg_valid && cfg_ready;
  assign term      = (cnt == half);

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign running = (state != ST_STOP);

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state    <= ST_STOP;
      cnt      <= '0;
      half     <= DEFAULT_HALF;
      pend_val <= '0;
      pend     <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      half     <= half_n;
      pend_val <= pend_val_n;
      pend     <= pend_n;
      clk_q    <= clk_n;
      tick_q   <= tick_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    half_n     = half;
    pend_val_n = pend_val;
    pend_n     = pend;
    clk_n      = clk_q;
    tick_n     = 1'b0;
    stop_now   = 1'b0;

    case (state)
      ST_STOP: begin
        cnt_n = '0;
        clk_n = 1'b0;
        if (hs) begin
          half_n = cfg_half;
        end
        if (en) begin
          state_n = ST_RUN;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (state == ST_RUN && !en && !clk_q) begin
          // Low phase may be cut short; nothing visible is lost.
          stop_now = 1'b1;
        end else begin
          if (term) begin
            cnt_n  = '0;
            clk_n  = !clk_q;
            tick_n = !clk_q;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end

          if (hs) begin
            pend_n     = 1'b1;
            pend_val_n = cfg_half;
          end

          if (term && clk_q) begin
            // End of a full period: the only point where H may change
            // while counting. hs cannot coincide with pend here.
            if (state == ST_DRAIN || !en) begin
              stop_now = 1'b1;
            end else if (pend) begin
              half_n = pend_val;
              pend_n = 1'b0;
            end
          end else if (state == ST_RUN && !en) begin
            // High phase is never truncated: finish it in DRAIN.
            state_n = ST_DRAIN;
          end
        end
      end

      default: begin
        state_n = ST_STOP;
        cnt_n   = '0;
        clk_n   = 1'b0;
      end
    endcase

    // Leaving the counting states: whatever config is waiting (or arriving
    // in this very cycle) becomes H, since STOP has no boundary to wait for.
    if (stop_now) begin
      state_n = ST_STOP;
      cnt_n   = '0;
      clk_n   = 1'b0;
      tick_n  = 1'b0;
      pend_n  = 1'b0;
      if (hs) begin
        half_n = cfg_half;
      end else if (pend) begin
        half_n = pend_val;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
  localparam int CNT_W = 4;
  localparam int DEF_H = 3;

  logic             clk_50MHz = 1'b0;
  logic             reset_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             running;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=stopped 1=run 2=drain, m_p = cycles since the
  // start of the current period (low phase is p<=H, high phase p>H).
  int m_mode, m_h, m_p, m_pend, m_pv;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(CNT_W'(DEF_H))) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_ready();
    return (m_mode == 0 || m_pend == 0) ? 1 : 0;
  endfunction

  function automatic int m_clk();
    return (m_mode != 0 && m_p >= m_h + 1) ? 1 : 0;
  endfunction

  function automatic int m_tick();
    return (m_mode != 0 && m_p == m_h + 1) ? 1 : 0;
  endfunction

  task automatic model_step(input bit rst, input bit e, input bit v, input int hv);
    bit hs;
    bit last;
    if (!rst) begin
      m_mode = 0; m_h = DEF_H; m_p = 0; m_pend = 0; m_pv = 0;
      return;
    end
    hs = v && (m_ready() == 1);
    if (m_mode == 0) begin
      if (hs) m_h = hv;
      if (e) begin
        m_mode = 1;
        m_p    = 0;
      end
    end else begin
      last = (m_p == 2 * m_h + 1);
      if ((m_mode == 1 && !e && m_p < m_h + 1) || (last && (m_mode == 2 || !e))) begin
        if (hs) m_h = hv;
        else if (m_pend != 0) m_h = m_pv;
        m_pend = 0;
        m_mode = 0;
        m_p    = 0;
      end else begin
        if (m_mode == 1 && !e) m_mode = 2;
        if (last) begin
          m_p = 0;
          if (m_pend != 0) begin
            m_h    = m_pv;
            m_pend = 0;
          end
        end else begin
          m_p++;
        end
        if (hs) begin
          m_pend = 1;
          m_pv   = hv;
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit e, input bit v, input int hv);
    reset_n   = rst;
    en        = e;
    cfg_valid = v;
    cfg_half  = hv[CNT_W-1:0];
    #1;
    check("cfg_ready", int'(cfg_ready), m_ready());
    @(posedge clk_50MHz);
    model_step(rst, e, v, hv);
    @(negedge clk_50MHz);
    check("clk_out", int'(clk_out), m_clk());
    check("tick", int'(tick), m_tick());
    check("running", int'(running), (m_mode != 0) ? 1 : 0);
  endtask

  task automatic wait_clk(input int val);
    int guard;
    guard = 0;
    while (int'(clk_out) != val && guard < 80) begin
      cycle(1, 1, 0, 0);
      guard++;
    end
    check("wait_clk", int'(clk_out), val);
  endtask

  initial begin
    int t0, t1, hi, guard;
    bit e_r;

    reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    @(posedge clk_50MHz);
    model_step(0, 0, 0, 0);
    @(negedge clk_50MHz);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_running", int'(running), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    cycle(1, 0, 0, 0);

    // Default H=3: rise at RUN cycle 4, period 8, four ticks in 30 cycles.
    t0 = -1; t1 = -1; hi = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0, 0);
      if (tick) begin
        hi++;
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
    end
    check("default_first_rise", t0, 4);
    check("default_period", t1 - t0, 8);
    check("default_tick_count", hi, 4);

    // Stop while low: stopped next cycle, no tick.
    wait_clk(0);
    cycle(1, 0, 0, 0);
    check("stop_low_running", int'(running), 0);
    check("stop_low_tick", int'(tick), 0);

    // Config H=1 in STOP together with en.
    t0 = -1; t1 = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, (i == 0), 1);
      if (tick) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
    end
    check("stop_cfg_first_rise", t0, 2);
    check("stop_cfg_period", t1 - t0, 4);

    // Back to H=3 from STOP, then offer H=0 mid high phase.
    wait_clk(0);
    cycle(1, 0, 1, 3);
    cycle(1, 1, 0, 0);
    wait_clk(1);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    check("mid_ready_low", int'(cfg_ready), 0);
    guard = 0;
    while (!cfg_ready && guard < 20) begin
      cycle(1, 1, 1, 5);
      guard++;
    end
    check("mid_ready_back", int'(cfg_ready), 1);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, 0);
      if (tick) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
    end
    check("mid_new_period", t1 - t0, 2);

    // Stop while high with H=3; en re-raised during DRAIN.
    cycle(1, 1, 1, 3);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
    wait_clk(1);
    hi = 1;
    guard = 0;
    e_r = 1'b0;
    while (running && guard < 20) begin
      cycle(1, e_r, 0, 0);
      e_r = 1'b1;
      if (clk_out) hi++;
      guard++;
    end
    check("drain_high_len", hi, 4);
    check("drain_stop_clk", int'(clk_out), 0);
    cycle(1, 1, 0, 0);
    check("drain_reenter", int'(running), 1);

    // Reset mid-run with a pending config.
    wait_clk(1);
    cycle(1, 1, 1, 1);
    cycle(0, 1, 0, 0);
    check("midrst_clk_out", int'(clk_out), 0);
    check("midrst_running", int'(running), 0);
    check("midrst_ready", int'(cfg_ready), 1);
    t0 = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, 0);
      if (tick && t0 < 0) t0 = i;
    end
    check("midrst_first_rise", t0, 4);

    // Randomized traffic against the model.
    e_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) e_r = !e_r;
      cycle(($urandom_range(399) != 0), e_r, ($urandom_range(5) == 0),
            int'($urandom_range(15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
